// File: rtl/calc_pkg.sv
// Shared key codes, limits, FSM state encoding and sign-magnitude packing
// for the BCD keypad entry controller.
package calc_pkg;

  localparam logic [3:0] KEY_SIGN  = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;

  localparam logic [9:0] MAX_MAG    = 10'd127;
  localparam logic [1:0] MAX_DIGITS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_CONV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // A zero magnitude never carries a minus sign.
  function automatic logic [7:0] pack_sm(input logic sign, input logic [6:0] mag);
    return {sign & (mag != 7'd0), mag};
  endfunction

endpackage

// File: rtl/bcd_accum.sv
// Decimal accumulator for keypad entry: acc = acc*10 + digit and a count
// of the digits taken so far.
module bcd_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic [3:0] digit,
  output logic [9:0] acc,
  output logic [1:0] digit_cnt
);

  logic [9:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;

  // The controller only pushes while fewer than three digits are held,
  // so acc never exceeds 999 and fits in 10 bits.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = 10'd0;
      cnt_d = 2'd0;
    end else if (push) begin
      acc_d = (acc_q << 3) + (acc_q << 1) + {6'd0, digit};
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 10'd0;
      cnt_q <= 2'd0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc       = acc_q;
  assign digit_cnt = cnt_q;

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Keypad entry controller: collects up to three BCD digits and a sign,
// then writes a sign-magnitude byte to a register bank.
// Optional macro BCD_SAT_EN: saturate overflow to 127 instead of erroring.
//
// state    | meaning
// ST_IDLE  | no digits entered, waiting for a key
// ST_ENTRY | one or more digits held
// ST_CONV  | one-cycle range check and packing of wr_data
// ST_WRITE | wr_en high until the register bank accepts
// ST_ERROR | overflow or too many digits; only CLEAR leaves
module bcd_entry_ctrl
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [2:0] dst_addr,
  input  logic       wr_ready,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err,
  output logic [1:0] digit_cnt
);

  state_t     state_q, state_d;
  logic       sign_q, sign_d;
  logic       err_q, err_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       acc_clr, acc_push;
  logic [9:0] acc;

  bcd_accum u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .push      (acc_push),
    .digit     (key_code),
    .acc       (acc),
    .digit_cnt (digit_cnt)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    err_d    = err_q;
    addr_d   = addr_q;
    data_d   = data_q;
    acc_clr  = 1'b0;
    acc_push = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (digit_cnt < MAX_DIGITS) begin
              acc_push = 1'b1;
              state_d  = ST_ENTRY;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          end else if (key_code == KEY_SIGN) begin
            sign_d = ~sign_q;
          end else if (key_code == KEY_CLEAR) begin
            state_d = ST_IDLE;
            sign_d  = 1'b0;
            err_d   = 1'b0;
            acc_clr = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            addr_d  = dst_addr;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        if (acc > MAX_MAG) begin
`ifdef BCD_SAT_EN
          data_d  = pack_sm(sign_q, 7'h7F);
          err_d   = 1'b0;
          state_d = ST_WRITE;
`else
          err_d   = 1'b1;
          state_d = ST_ERROR;
`endif
        end else begin
          data_d  = pack_sm(sign_q, acc[6:0]);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          state_d = ST_IDLE;
          sign_d  = 1'b0;
          acc_clr = 1'b1;
        end
      end
      ST_ERROR: begin
        if (key_valid && key_code == KEY_CLEAR) begin
          state_d = ST_IDLE;
          sign_d  = 1'b0;
          err_d   = 1'b0;
          acc_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 3'd0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_en   = (state_q == ST_WRITE);
  assign busy    = (state_q == ST_CONV) || (state_q == ST_WRITE);
  assign err     = err_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Directed self-checking bench for bcd_entry_ctrl; honours BCD_SAT_EN when
// the design is built with it.
module tb_bcd_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] dst_addr;
  logic       wr_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;
  logic [1:0] digit_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int xfers = 0;

  localparam logic [3:0] K_SIGN  = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;
  localparam logic [3:0] K_ENTER = 4'd12;

  bcd_entry_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .dst_addr  (dst_addr),
    .wr_ready  (wr_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .err       (err),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && wr_en && wr_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe one key for exactly one rising edge; returns at the following negedge.
  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; dst_addr = 3'd0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1,2,7,ENTER to addr 5: +127
    wr_ready = 1'b1; dst_addr = 3'd5;
    press(4'd1); chk("a_cnt1", 32'(digit_cnt), 32'd1);
    press(4'd2); chk("a_cnt2", 32'(digit_cnt), 32'd2);
    press(4'd7); chk("a_cnt3", 32'(digit_cnt), 32'd3);
    press(K_ENTER);
    dst_addr = 3'd2;
    chk("a_conv_busy", 32'(busy), 32'd1);
    chk("a_conv_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    chk("a_wr_en", 32'(wr_en), 32'd1);
    chk("a_wr_addr", 32'(wr_addr), 32'd5);
    chk("a_wr_data", 32'(wr_data), 32'h7F);
    @(negedge clk);
    chk("a_done_wr_en", 32'(wr_en), 32'd0);
    chk("a_done_busy", 32'(busy), 32'd0);
    chk("a_done_cnt", 32'(digit_cnt), 32'd0);
    chk("a_xfers", 32'(xfers), 32'd1);

    // SIGN,4,2,ENTER with 3 wait states: -42 = 0xAA held 4 cycles
    wr_ready = 1'b0; dst_addr = 3'd3;
    press(K_SIGN); chk("b_sign_cnt", 32'(digit_cnt), 32'd0);
    press(4'd4);
    press(4'd2);
    press(K_ENTER);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_wr_en_hold", 32'(wr_en), 32'd1);
      chk("b_wr_data_hold", 32'(wr_data), 32'hAA);
      chk("b_wr_addr_hold", 32'(wr_addr), 32'd3);
      if (i == 3) wr_ready = 1'b1;
    end
    @(negedge clk);
    chk("b_done_wr_en", 32'(wr_en), 32'd0);
    chk("b_xfers", 32'(xfers), 32'd2);

    // 1,2,8,ENTER: overflow
    press(4'd1); press(4'd2); press(4'd8); press(K_ENTER);
    @(negedge clk);
`ifdef BCD_SAT_EN
    chk("c_sat_wr_en", 32'(wr_en), 32'd1);
    chk("c_sat_data", 32'(wr_data), 32'h7F);
    chk("c_sat_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("c_sat_xfers", 32'(xfers), 32'd3);
`else
    chk("c_ovf_err", 32'(err), 32'd1);
    chk("c_ovf_wr_en", 32'(wr_en), 32'd0);
    chk("c_ovf_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("c_ovf_wr_en2", 32'(wr_en), 32'd0);
    chk("c_ovf_xfers", 32'(xfers), 32'd2);
    press(K_CLEAR);
    chk("c_clear_err", 32'(err), 32'd0);
`endif

    // 1,2,3,4: fourth digit errors; ENTER ignored; CLEAR recovers
    press(4'd1); press(4'd2); press(4'd3);
    chk("d_cnt3", 32'(digit_cnt), 32'd3);
    chk("d_err_before", 32'(err), 32'd0);
    press(4'd4);
    chk("d_err_set", 32'(err), 32'd1);
    press(K_ENTER);
    @(negedge clk);
    chk("d_enter_ign_busy", 32'(busy), 32'd0);
    chk("d_enter_ign_wr_en", 32'(wr_en), 32'd0);
    chk("d_enter_ign_err", 32'(err), 32'd1);
    press(K_CLEAR);
    chk("d_clear_err", 32'(err), 32'd0);
    chk("d_clear_cnt", 32'(digit_cnt), 32'd0);

    // CLEAR in ENTRY drops sign and digits: 5,SIGN,CLEAR,9,ENTER -> +9
    press(4'd5); press(K_SIGN); press(K_CLEAR);
    chk("e_clear_cnt", 32'(digit_cnt), 32'd0);
    press(4'd9); press(K_ENTER);
    @(negedge clk);
    chk("e_wr_data", 32'(wr_data), 32'h09);
    @(negedge clk);
    chk("e_xfers", 32'(xfers), 32'd4 - ((`ifdef BCD_SAT_EN 0 `else 1 `endif)));

    // SIGN,ENTER -> 0x00; keys ignored while busy; reset mid-WRITE
    wr_ready = 1'b0; dst_addr = 3'd6;
    press(K_SIGN); press(K_ENTER);
    key_valid = 1'b1; key_code = K_CLEAR;
    @(negedge clk);
    key_code = 4'd9;
    chk("f_wr_en", 32'(wr_en), 32'd1);
    chk("f_zero_data", 32'(wr_data), 32'h00);
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("f_busy_ign_wr_en", 32'(wr_en), 32'd1);
    chk("f_busy_ign_cnt", 32'(digit_cnt), 32'd0);
    rst = 1'b1; wr_ready = 1'b1; key_valid = 1'b1; key_code = 4'd7;
    @(negedge clk);
    chk("f_rst_wr_en", 32'(wr_en), 32'd0);
    chk("f_rst_busy", 32'(busy), 32'd0);
    chk("f_rst_data", 32'(wr_data), 32'd0);
    chk("f_rst_addr", 32'(wr_addr), 32'd0);
    chk("f_rst_cnt", 32'(digit_cnt), 32'd0);
    chk("f_rst_err", 32'(err), 32'd0);
    chk("f_rst_xfers", 32'(xfers), 32'd4 - ((`ifdef BCD_SAT_EN 0 `else 1 `endif)));
    rst = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    @(negedge clk);

    // Sign was cleared by reset: 3,ENTER -> +3
    press(4'd3); press(K_ENTER);
    @(negedge clk);
    chk("g_wr_data", 32'(wr_data), 32'h03);
    chk("g_wr_addr", 32'(wr_addr), 32'd6);
    @(negedge clk);
    chk("g_xfers", 32'(xfers), 32'd5 - ((`ifdef BCD_SAT_EN 0 `else 1 `endif)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
